// File: rtl/risc_pkg.sv
// Shared types and constants for the loadable instruction memory.
package risc_pkg;

    localparam int          INSTR_WORD_W   = 32;
    localparam logic [31:0] ILLOP_WORD_DEF = 32'hFFFF_FFFF;

    // Bit positions within id_fault
    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } im_state_t;

endpackage

// File: rtl/instr_mem_ram.sv
// Single-port synchronous RAM, registered read; a write cycle leaves rdata untouched.
module instr_mem_ram
    import risc_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [AW-1:0]           addr,
    input  logic [INSTR_WORD_W-1:0] wdata,
    output logic [INSTR_WORD_W-1:0] rdata
);

    logic [INSTR_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Writable instruction memory: clear sweep after reset, ready/valid burst loader, faulting fetch.
// Build option INSTR_MEM_WP_EN write-protects the first PROT_WORDS words against loads.
module instr_mem_loadable
    import risc_pkg::*;
#(
    parameter int          DEPTH      = 128,
    parameter logic [31:0] ILLOP_WORD = ILLOP_WORD_DEF,
    parameter int          LEN_W      = $clog2(DEPTH) + 1,
    parameter int          PROT_WORDS = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic [31:0]      pc,
    output logic [31:0]      id,
    output logic             id_valid,
    output logic [1:0]       id_fault,
    input  logic             ld_start,
    input  logic [31:0]      ld_base,
    input  logic [LEN_W-1:0] ld_len,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    output logic             ld_ready,
    output logic             ld_done,
    output logic             ld_err,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

`ifdef INSTR_MEM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    im_state_t         state_q, state_d;
    logic [AW-1:0]     clr_ptr;
    logic [29:0]       wptr;
    logic [LEN_W-1:0]  remaining;
    logic              err_q;
    logic              ill_q;

    logic              accept, wr_ok, wr_prot, fetch_ok;
    logic [1:0]        fault_d;
    logic              ram_en, ram_we;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic              unused_bits;

    assign unused_bits = ^ld_base[1:0];

    assign accept   = (state_q == ST_LOAD) && ld_valid;
    assign wr_prot  = WP_ON && (wptr < 30'(PROT_WORDS));
    assign wr_ok    = ((wptr >> AW) == '0) && !wr_prot;
    assign fetch_ok = fetch_en && (state_q == ST_IDLE || state_q == ST_DONE);

    assign fault_d[FAULT_MISALIGN] = (pc[1:0] != 2'b00);
    assign fault_d[FAULT_RANGE]    = ((pc[31:2] >> AW) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_CLEAR;
        else     state_q <= state_d;
    end

    // Single RAM port shared by the sweep, the loader and fetch; states keep them disjoint.
    always_comb begin
        state_d   = state_q;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        ld_err    = 1'b0;
        busy      = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = pc[AW+1:2];
        ram_wdata = ld_data;
        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_ptr;
                ram_wdata = ILLOP_WORD;
                if (clr_ptr == AW'(DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                ram_en = fetch_ok;
                if (ld_start) state_d = (ld_len == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                busy     = 1'b1;
                ld_ready = 1'b1;
                ram_en   = accept && wr_ok;
                ram_we   = accept && wr_ok;
                ram_addr = wptr[AW-1:0];
                if (accept && remaining == LEN_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                ld_done = 1'b1;
                ld_err  = err_q;
                ram_en  = fetch_ok;
                state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_ptr   <= '0;
            wptr      <= '0;
            remaining <= '0;
            err_q     <= 1'b0;
            id_valid  <= 1'b0;
            id_fault  <= 2'b00;
            ill_q     <= 1'b1;
        end else begin
            if (state_q == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
            if (state_q == ST_IDLE && ld_start) begin
                wptr      <= ld_base[31:2];
                remaining <= ld_len;
                err_q     <= 1'b0;
            end
            if (accept) begin
                wptr      <= wptr + 30'd1;
                remaining <= remaining - 1'b1;
                if (!wr_ok) err_q <= 1'b1;
            end
            id_valid <= fetch_ok;
            id_fault <= fetch_ok ? fault_d : 2'b00;
            if (fetch_ok) ill_q <= (fault_d != 2'b00);
        end
    end

    // ill_q masks the RAM output so a faulted fetch (or reset) presents ILLOP_WORD.
    assign id = ill_q ? ILLOP_WORD : ram_rdata;

    instr_mem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: fixed vectors, directed corner sequences, random loads vs. array model.
module tb_instr_mem_loadable;

    localparam int          DEPTH = 128;
    localparam int          LEN_W = 8;
    localparam int          PROT  = 20;
    localparam logic [31:0] ILLOP = 32'hFFFF_FFFF;
`ifdef INSTR_MEM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             fetch_en;
    logic [31:0]      pc;
    logic [31:0]      id;
    logic             id_valid;
    logic [1:0]       id_fault;
    logic             ld_start;
    logic [31:0]      ld_base;
    logic [LEN_W-1:0] ld_len;
    logic             ld_valid;
    logic [31:0]      ld_data;
    logic             ld_ready, ld_done, ld_err, busy;

    instr_mem_loadable #(.DEPTH(DEPTH), .ILLOP_WORD(ILLOP), .LEN_W(LEN_W), .PROT_WORDS(PROT)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc(pc), .id(id), .id_valid(id_valid),
        .id_fault(id_fault), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
        .ld_err(ld_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] ldq [$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_id;
        logic [1:0]  exp_fault;
    } fvec_t;
    fvec_t tbl [8];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) model[i] = ILLOP;
    endtask

    task automatic wait_clear;
        int n = 0;
        int saw_done = 0;
        while (busy === 1'b1 && n < 300) begin
            step;
            n++;
            if (ld_done === 1'b1) saw_done++;
        end
        chk("clear_cycles", n, 128);
        chk("no_done_in_clear", saw_done, 0);
    endtask

    // Expected result from address arithmetic and the model array.
    task automatic fetch(input logic [31:0] a);
        logic [1:0]  ef;
        logic [31:0] eid;
        ef[0] = (a % 4) != 0;
        ef[1] = (a / 4) >= DEPTH;
        eid   = ILLOP;
        if (ef == 2'b00) eid = model[a / 4];
        fetch_en = 1'b1;
        pc       = a;
        step;
        fetch_en = 1'b0;
        chk($sformatf("id_valid@%h", a), id_valid, 1);
        chk($sformatf("id_fault@%h", a), id_fault, ef);
        chk($sformatf("id@%h", a), id, eid);
    endtask

    task automatic load(input logic [31:0] base, input int len, input bit gaps);
        bit e = 0;
        for (int k = 0; k < len; k++) begin
            int idx = int'(base / 4) + k;
            if (idx >= DEPTH || (WP && idx < PROT)) e = 1;
            else model[idx] = ldq[k];
        end
        ld_start = 1'b1;
        ld_base  = base;
        ld_len   = LEN_W'(len);
        step;
        ld_start = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    ld_valid = 1'b0;
                    ld_data  = $urandom;
                    step;
                end
            end
            ld_valid = 1'b1;
            ld_data  = ldq[k];
            chk("ld_ready", ld_ready, 1);
            step;
        end
        ld_valid = 1'b0;
        chk($sformatf("ld_done@%h", base), ld_done, 1);
        chk($sformatf("ld_err@%h", base), ld_err, e);
        step;
        chk("ld_done_pulse", ld_done, 0);
        chk("busy_after_load", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fetch_en = 0; pc = 0; ld_start = 0; ld_base = 0;
        ld_len = 0; ld_valid = 0; ld_data = 0;
        model_clear;
        repeat (2) step;
        chk("rst_id", id, ILLOP);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_fault", id_fault, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_ld_err", ld_err, 0);
        chk("rst_busy", busy, 1);
        rst = 1'b0;
        wait_clear;

        // Sweep result and ordinary load
        fetch(32'h40);
        ldq = '{32'hA, 32'hB, 32'hC};
        load(32'h50, 3, 1'b1);

        tbl[0] = '{32'h50,  32'h0000_000A, 2'b00};
        tbl[1] = '{32'h54,  32'h0000_000B, 2'b00};
        tbl[2] = '{32'h58,  32'h0000_000C, 2'b00};
        tbl[3] = '{32'h5C,  ILLOP,         2'b00};
        tbl[4] = '{32'h52,  ILLOP,         2'b01};
        tbl[5] = '{32'h200, ILLOP,         2'b10};
        tbl[6] = '{32'h203, ILLOP,         2'b11};
        tbl[7] = '{32'h1FC, ILLOP,         2'b00};
        for (int i = 0; i < 8; i++) begin
            fetch_en = 1'b1;
            pc       = tbl[i].pc;
            step;
            fetch_en = 1'b0;
            chk($sformatf("tbl%0d_valid", i), id_valid, 1);
            chk($sformatf("tbl%0d_fault", i), id_fault, tbl[i].exp_fault);
            chk($sformatf("tbl%0d_id", i), id, tbl[i].exp_id);
        end

        // Id holds when no fetch
        step;
        chk("hold_valid", id_valid, 0);
        chk("hold_id", id, ILLOP);

        // Burst running off the end of the array
        ldq = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004};
        load(32'h1F8, 4, 1'b0);
        fetch(32'h1F8);
        fetch(32'h1FC);
        chk("edge_word", id, 32'h1111_0002);

        // Zero-length burst
        ldq = {};
        load(32'h100, 0, 1'b0);
        fetch(32'h100);

        // ld_valid in IDLE is not consumed
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        chk("idle_ready", ld_ready, 0);
        step;
        ld_valid = 1'b0;
        chk("idle_busy", busy, 0);

        // Random bursts against the model
        repeat (8) begin
            int          len  = $urandom_range(1, 6);
            logic [31:0] base = 32'($urandom_range(0, 135)) << 2;
            ldq = {};
            for (int k = 0; k < len; k++) ldq.push_back($urandom);
            load(base, len, 1'b1);
        end
        repeat (30) begin
            logic [31:0] a = 32'($urandom_range(0, 135)) << 2;
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            fetch(a);
        end

        // Reset in the middle of a burst
        ld_start = 1'b1; ld_base = 32'h50; ld_len = LEN_W'(5);
        step;
        ld_start = 1'b0;
        repeat (2) begin
            ld_valid = 1'b1; ld_data = $urandom;
            step;
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1);
        chk("midrst_ready", ld_ready, 0);
        chk("midrst_done", ld_done, 0);
        step;
        rst = 1'b0;
        model_clear;
        wait_clear;
        fetch(32'h50);
        fetch(32'h1F8);

        // Word 0 under optional write protection
        ldq = '{32'h0000_1234};
        load(32'h0, 1, 1'b0);
        fetch(32'h0);
        chk("word0", id, WP ? ILLOP : 32'h0000_1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised, writable instruction memory for the RISC core; successor to the hard-wired instruction table.
- Holds DEPTH 32-bit words, fetched by byte-addressed pc with one-cycle registered latency.
- Clears itself to ILLOP_WORD after reset.
- Accepts program images through a ready/valid burst-load port, so the save/load programs no longer need to be compiled in.
- Flags illegal fetches (misaligned or out of range) to the control unit.

Parameters:
DEPTH, 128, number of 32-bit instruction words (power of two, >= 4).
ILLOP_WORD, 32'hFFFF_FFFF, word returned on faulted fetch and written by the clear sweep.
LEN_W, $clog2(DEPTH)+1, width of burst length.
PROT_WORDS, 20, words from index 0 that are write-protected (program selector region); used only with INSTR_MEM_WP_EN.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
fetch_en  in  1  fetch request for pc this cycle
pc  in  32  byte address of instruction
id  out  32  fetched instruction word
id_valid  out  1  id holds result of fetch issued previous cycle
id_fault  out  2  bit0 misaligned (pc[1:0]!=0), bit1 out of range (pc>>2 >= DEPTH)
ld_start  in  1  begin burst load (sampled in IDLE only)
ld_base  in  32  byte start address of burst (bits [1:0] ignored)
ld_len  in  LEN_W  number of words in burst
ld_valid  in  1  ld_data valid
ld_data  in  32  instruction word to write
ld_ready  out  1  memory accepts ld_data this cycle
ld_done  out  1  one-cycle pulse: burst complete
ld_err  out  1  valid with ld_done: at least one word dropped (out of range or protected)
busy  out  1  high in CLEAR or LOAD

Behaviour:
- Reset (async, rst high): state=CLEAR, clr_ptr=0; id=ILLOP_WORD, id_valid=0, id_fault=0, ld_ready=0, ld_done=0, ld_err=0, busy=1. Memory contents are not reset directly; the sweep overwrites them.
- CLEAR: writes ILLOP_WORD to mem[clr_ptr] each cycle, clr_ptr++. After writing index DEPTH-1 → IDLE. Takes exactly DEPTH cycles after reset deassertion. Protection does not apply to the sweep.
- IDLE: busy=0, ld_ready=0.
  - ld_start=1 → LOAD; wptr=ld_base[31:2], remaining=ld_len, err=0.
  - ld_start with ld_len=0 → DONE directly.
- LOAD: ld_ready=1, busy=1.
  - On ld_valid&&ld_ready: if wptr<DEPTH (and not protected), mem[wptr]<=ld_data; else drop and set err. Then wptr++ and remaining--.
  - wptr is 30 bits and does not wrap within DEPTH; words past DEPTH-1 are dropped.
  - Acceptance that brings remaining to 0 → DONE.
  - ld_valid while ld_ready=0 is ignored; the word is not consumed.
- DONE: ld_done=1 and ld_err=err for one cycle → IDLE. ld_start in DONE is ignored.
- ld_start outside IDLE is ignored.
- Fetch:
  - fetch_en in cycle N with state IDLE or DONE → cycle N+1: id_valid=1, id_fault computed from pc. If id_fault!=0, id=ILLOP_WORD; else id=mem[pc[31:2]].
  - fetch_en during CLEAR/LOAD → cycle N+1: id_valid=0, id holds last value. The core must stall on busy.
  - No fetch_en → id_valid=0, id holds last value.
  - Write and fetch never coincide, so no read-during-write hazard exists.
- Reset asserted mid-LOAD: burst aborted with no ld_done; memory re-cleared in full.

Optional Feature:
INSTR_MEM_WP_EN:
- Defined: LOAD writes to indices < PROT_WORDS are dropped and set err; ld_err reports it.
- Undefined: the whole array is writable; PROT_WORDS is unused.

Decomposition:
- Shared package (risc_pkg): state enum {CLEAR, IDLE, LOAD, DONE}, ILLOP_WORD default, fault bit indices, and INSTR_WORD_W=32.
- One sub-module: instr_mem_ram, a single-port synchronous RAM (DEPTH×32, registered read, write enable), with the address mux between clear/load/fetch in the parent.

Test Plan:
1. Reset, wait 128 cycles, fetch pc=0x40 → busy falls at cycle 128; id=32'hFFFF_FFFF, id_valid=1, id_fault=0.
2. Load ld_base=0x50, ld_len=3, data 0xA,0xB,0xC with ld_valid gaps → ld_done 1 cycle after third accept, ld_err=0; fetch 0x50/0x54/0x58 returns 0xA/0xB/0xC.
3. Fetch pc=0x52 → id_fault=2'b01, id=ILLOP_WORD. Fetch pc=0x200 (DEPTH=128) → id_fault=2'b10, id=ILLOP_WORD.
4. Load ld_base=0x1F8, ld_len=4 → words at 0x1F8 and 0x1FC written; 2 dropped; ld_err=1. ld_len=0 → ld_done next cycle with no write.
5. Assert rst after 2 of 5 words accepted → no ld_done; after 128 cycles, fetch 0x50 returns ILLOP_WORD.
6. With INSTR_MEM_WP_EN: load ld_base=0x0, ld_len=1, data 0x1234 → ld_err=1 and mem[0] unchanged. Without the macro → mem[0]=0x1234, ld_err=0.
